// File: rtl/csa_multiword_arbiter.sv
// Two-requester round-robin front end that streams multi-limb additions
// through one shared carry-select adder, one limb per cycle.

module carry_select_adder #(
  parameter int WIDTH      = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NB = WIDTH / BLOCK_SIZE;
  localparam int BS = BLOCK_SIZE;

  logic [NB:0] w_c;

  assign w_c[0] = i_cin;

  // Each block precomputes both carry-in cases; the ripple only muxes.
  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BS:0] w_s0;
    logic [BS:0] w_s1;

    assign w_s0 = {1'b0, i_a[g*BS +: BS]}
                + {1'b0, i_b[g*BS +: BS]};
    assign w_s1 = {1'b0, i_a[g*BS +: BS]}
                + {1'b0, i_b[g*BS +: BS]}
                + (BS+1)'(1);

    assign o_sum[g*BS +: BS] = w_c[g] ? w_s1[BS-1:0]
                                      : w_s0[BS-1:0];
    assign w_c[g+1] = w_c[g] ? w_s1[BS] : w_s0[BS];
  end

  assign o_cout = w_c[NB];

endmodule

module csa_multiword_arbiter #(
  parameter int WIDTH      = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int LIMBS      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH*LIMBS-1:0] req0_a,
  input  logic [WIDTH*LIMBS-1:0] req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH*LIMBS-1:0] req1_a,
  input  logic [WIDTH*LIMBS-1:0] req1_b,
  input  logic                   req1_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH*LIMBS-1:0] rsp_sum,
  output logic                   rsp_cout
);

  localparam int OPW = WIDTH * LIMBS;
  localparam int CW  = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_last;
  logic            r_carry;
  logic            r_id;
  logic            r_cout;
  logic            r_valid;
  logic [CW-1:0]   r_cnt;
  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic [WIDTH-1:0] r_sum [LIMBS];

  logic [WIDTH-1:0] w_a_l [LIMBS];
  logic [WIDTH-1:0] w_b_l [LIMBS];
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_g0;
  logic             w_g1;
  logic             w_idle;
  logic             w_acc;

  for (genvar i = 0; i < LIMBS; i++) begin : g_limb
    assign w_a_l[i] = r_a[i*WIDTH +: WIDTH];
    assign w_b_l[i] = r_b[i*WIDTH +: WIDTH];
    assign rsp_sum[i*WIDTH +: WIDTH] = r_sum[i];
  end

  // r_last names the previous winner; the other side wins a tie.
  assign w_g0   = req0_valid & (~req1_valid | r_last);
  assign w_g1   = req1_valid & (~req0_valid | ~r_last);
  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = w_idle & (w_g0 | w_g1);

  assign req0_ready = w_idle & w_g0;
  assign req1_ready = w_idle & w_g1;
  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_cout   = r_cout;

  carry_select_adder #(
    .WIDTH      (WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_csa (
    .i_a    (w_a_l[r_cnt]),
    .i_b    (w_b_l[r_cnt]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      for (int i = 0; i < LIMBS; i++) begin
        r_sum[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_a     <= w_g1 ? req1_a : req0_a;
            r_b     <= w_g1 ? req1_b : req0_b;
            r_carry <= w_g1 ? req1_cin : req0_cin;
            r_id    <= w_g1;
            r_last  <= w_g1;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_cnt] <= w_sum;
          r_carry      <= w_cout;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_cout  <= w_cout;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_multiword_arbiter.sv
// Scoreboard bench for csa_multiword_arbiter: table of single ops plus
// contention, backpressure and reset-in-flight sequences.

module tb_csa_multiword_arbiter;

  localparam int W   = 8;
  localparam int BS  = 4;
  localparam int L   = 4;
  localparam int OPW = W * L;

  typedef struct {
    logic           id;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           cin;
    logic [OPW-1:0] sum;
    logic           cout;
  } vec_t;

  typedef struct {
    logic           id;
    logic [OPW-1:0] sum;
    logic           cout;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_a;
  logic [OPW-1:0] req0_b;
  logic           req0_cin;
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_a;
  logic [OPW-1:0] req1_b;
  logic           req1_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [OPW-1:0] rsp_sum;
  logic           rsp_cout;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[7];

  csa_multiword_arbiter #(
    .WIDTH      (W),
    .BLOCK_SIZE (BS),
    .LIMBS      (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Handshake edge follows this negedge; compare against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual_id=%0h required=none",
                 rsp_id);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_sum", 64'(rsp_sum), 64'(mon_e.sum));
        chk("rsp_cout", 64'(rsp_cout), 64'(mon_e.cout));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=%0d required=<30", n);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_sum"}, 64'(rsp_sum), 64'd0);
    chk({tag, "_cout"}, 64'(rsp_cout), 64'd0);
    chk({tag, "_rdy"}, 64'({req0_ready, req1_ready}), 64'd0);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst");
    q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    int n;
    if (v.id) begin
      req1_valid = 1'b1;
      req1_a = v.a;
      req1_b = v.b;
      req1_cin = v.cin;
    end else begin
      req0_valid = 1'b1;
      req0_a = v.a;
      req0_b = v.b;
      req0_cin = v.cin;
    end
    #1;
    chk("ready_own", 64'(v.id ? req1_ready : req0_ready), 64'd1);
    chk("ready_other", 64'(v.id ? req0_ready : req1_ready), 64'd0);
    q.push_back('{v.id, v.sum, v.cout});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = $urandom;
    req0_b = $urandom;
    req1_a = $urandom;
    req1_b = $urandom;
    chk("ready_run", 64'({req0_ready, req1_ready}), 64'd0);
    wait_rsp(n);
    chk("latency", 64'(n), 64'(L));
    handshake();
    chk("valid_after_hs", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   last_det;
    logic mlast;
    logic exp_id;
    logic seen;

    tbl[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0,
               32'h00000100, 1'b0};
    tbl[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1,
               32'h00000000, 1'b1};
    tbl[2] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0,
               32'h23456789, 1'b0};
    tbl[3] = '{1'b1, 32'h80000000, 32'h80000000, 1'b0,
               32'h00000000, 1'b1};
    tbl[4] = '{1'b0, 32'h0F0F0F0F, 32'h01010101, 1'b1,
               32'h10101011, 1'b0};
    tbl[5] = '{1'b1, 32'hDEADBEEF, 32'h21524110, 1'b0,
               32'hFFFFFFFF, 1'b0};
    tbl[6] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               32'hFFFFFFFF, 1'b1};

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req0_cin = 1'b0;
    req1_a = '0;
    req1_b = '0;
    req1_cin = 1'b0;
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("por");
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_rdy", 64'({req0_ready, req1_ready}), 64'd0);
    end

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i]);
    end

    // Reset with a nonzero response held: outputs clear at once.
    do_reset();

    // Contention from a fresh grant pointer: 0,1,0,1 six cycles apart.
    req0_a = 32'h12345678;
    req0_b = 32'h11111111;
    req0_cin = 1'b0;
    req1_a = 32'h80000000;
    req1_b = 32'h80000000;
    req1_cin = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    mlast = 1'b1;
    last_det = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
        tick();
        n++;
      end
      exp_id = ~mlast;
      chk("cont_grant", 64'({req0_ready, req1_ready}),
          64'(exp_id ? 2'b01 : 2'b10));
      if (exp_id)
        q.push_back('{1'b1, 32'h00000000, 1'b1});
      else
        q.push_back('{1'b0, 32'h23456789, 1'b0});
      mlast = exp_id;
      if (i > 0) chk("cont_spacing", 64'(cyc - last_det), 64'd6);
      last_det = cyc;
      tick();
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("cont_drain", 64'(q.size()), 64'd0);
    rsp_ready = 1'b0;
    tick();

    // Backpressure in DONE with a pending req0.
    req0_a = 32'h01020304;
    req0_b = 32'h10203040;
    req0_cin = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("bp_ready", 64'(req0_ready), 64'd1);
    q.push_back('{1'b0, 32'h11223344, 1'b0});
    tick();
    req0_a = 32'h00000005;
    req0_b = 32'h00000006;
    wait_rsp(n);
    chk("bp_latency", 64'(n), 64'(L));
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum", 64'(rsp_sum), 64'h11223344);
      chk("bp_id_cout", 64'({rsp_id, rsp_cout}), 64'd0);
      chk("bp_rdy", 64'({req0_ready, req1_ready}), 64'd0);
      tick();
    end
    handshake();
    chk("bp_first_idle", 64'(req0_ready), 64'd1);
    q.push_back('{1'b0, 32'h0000000B, 1'b0});
    tick();
    req0_valid = 1'b0;
    wait_rsp(n);
    handshake();

    // Reset after two limbs of an in-flight op.
    req0_a = 32'hFFFFFFFF;
    req0_b = 32'h00000001;
    req0_valid = 1'b1;
    #1;
    chk("mr_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    do_reset();
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("mr_no_rsp", 64'(seen), 64'd0);
    req0_a = 32'h00000002;
    req0_b = 32'h00000003;
    req0_cin = 1'b0;
    req1_a = 32'h00000007;
    req1_b = 32'h00000007;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mr_ptr_reset", 64'({req0_ready, req1_ready}), 64'b10);
    q.push_back('{1'b0, 32'h00000005, 1'b0});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(n);
    chk("mr_latency", 64'(n), 64'(L));
    handshake();
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
